// File: rtl/dld_pkg.sv
// Shared constants for the operand loader: operand width and FSM state codes.
package dld_pkg;

    localparam int OPERAND_W = 4;

    localparam logic [1:0] ST_WAIT_A = 2'b00;
    localparam logic [1:0] ST_WAIT_B = 2'b01;
    localparam logic [1:0] ST_READY  = 2'b10;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-count debounce and a
// one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          btn_meta;
    logic          btn_sync;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            level    <= 1'b0;
            level_d  <= 1'b0;
            cnt      <= '0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
            level_d  <= level;
            // cnt holds how many consecutive cycles the synced input has disagreed
            if (btn_sync != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= btn_sync;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Both terms are registered, so the pulse is glitch-free and lasts one cycle.
    assign pulse = level & ~level_d;

endmodule

// File: rtl/operand_loader.sv
// Loads operand A then operand B from switches on debounced LOAD presses;
// CLEAR returns to the empty state. Feeds four_bit_add directly.
module operand_loader
    import dld_pkg::*;
#(
    parameter int WIDTH           = OPERAND_W,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_load,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] in2,
    output logic             operands_valid,
    output logic [1:0]       state_led
);

    logic [WIDTH-1:0] sw_meta;
    logic [WIDTH-1:0] sw_sync;
    logic             load_p;
    logic             clear_p;
    logic [1:0]       state;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_load),
        .pulse (load_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clear),
        .pulse (clear_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_WAIT_A;
            in1            <= '0;
            in2            <= '0;
            operands_valid <= 1'b0;
        end else if (clear_p) begin
            state          <= ST_WAIT_A;
            in1            <= '0;
            in2            <= '0;
            operands_valid <= 1'b0;
        end else if (state == 2'b11) begin
            state <= ST_WAIT_A;
        end else if (load_p) begin
            case (state)
                ST_WAIT_A: begin
                    in1   <= sw_sync;
                    state <= ST_WAIT_B;
                end
                ST_WAIT_B: begin
                    in2            <= sw_sync;
                    operands_valid <= 1'b1;
                    state          <= ST_READY;
                end
                ST_READY: begin
                    // in2 is kept so the previous B stays on the adder until reloaded
                    in1            <= sw_sync;
                    operands_valid <= 1'b0;
                    state          <= ST_WAIT_B;
                end
                default: state <= ST_WAIT_A;
            endcase
        end
    end

    assign state_led = state;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed board scenarios plus random button/switch
// activity, compared every cycle against a history-based behavioural model.
module tb_operand_loader;

    localparam int W = 4;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw;
    logic         btn_load;
    logic         btn_clear;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         operands_valid;
    logic [1:0]   state_led;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    operand_loader #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sw             (sw),
        .btn_load       (btn_load),
        .btn_clear      (btn_clear),
        .in1            (in1),
        .in2            (in2),
        .operands_valid (operands_valid),
        .state_led      (state_led)
    );

    // ---------------- behavioural model ----------------
    // Raw samples since reset; the value used at edge t is the one sampled at t-2.
    logic         hist_q[2][$];
    logic [W-1:0] sw_hist_q[$];
    logic         db[2];
    logic         rose[2];
    logic [W-1:0] m_in1;
    logic [W-1:0] m_in2;
    logic         m_valid;
    logic [1:0]   m_state;

    function automatic logic hist_at(int b, int idx);
        if (idx < 0) return 1'b0;
        return hist_q[b][idx];
    endfunction

    task automatic model_reset();
        hist_q[0].delete();
        hist_q[1].delete();
        sw_hist_q.delete();
        db[0] = 1'b0; db[1] = 1'b0;
        rose[0] = 1'b0; rose[1] = 1'b0;
        m_in1 = '0; m_in2 = '0; m_valid = 1'b0; m_state = 2'b00;
    endtask

    task automatic model_step();
        logic         lp;
        logic         cp;
        logic [W-1:0] s;
        int           t;
        bit           all_diff;
        lp = rose[0];
        cp = rose[1];
        t  = sw_hist_q.size() - 2;
        s  = (t < 0) ? '0 : sw_hist_q[t];
        if (cp) begin
            m_in1 = '0; m_in2 = '0; m_valid = 1'b0; m_state = 2'b00;
        end else if (lp) begin
            if (m_state == 2'b00) begin
                m_in1 = s; m_state = 2'b01;
            end else if (m_state == 2'b01) begin
                m_in2 = s; m_valid = 1'b1; m_state = 2'b10;
            end else begin
                m_in1 = s; m_valid = 1'b0; m_state = 2'b01;
            end
        end
        sw_hist_q.push_back(sw);
        hist_q[0].push_back(btn_load);
        hist_q[1].push_back(btn_clear);
        for (int b = 0; b < 2; b++) begin
            t = hist_q[b].size() - 1;
            all_diff = 1'b1;
            for (int k = 0; k < N; k++)
                if (hist_at(b, t - 2 - k) == db[b]) all_diff = 1'b0;
            rose[b] = 1'b0;
            if (all_diff) begin
                db[b]   = ~db[b];
                rose[b] = db[b];
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic l, input logic c, input logic [W-1:0] s, input int n);
        btn_load  = l;
        btn_clear = c;
        sw        = s;
        repeat (n) tick();
    endtask

    task automatic press_load(input logic [W-1:0] s);
        drive(1'b1, 1'b0, s, 10);
        drive(1'b0, 1'b0, s, 10);
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (in1 !== m_in1 || in2 !== m_in2 || operands_valid !== m_valid ||
                state_led !== m_state) begin
                failures++;
                $display("FAIL cycle_cmp @%0t: got in1=%0d in2=%0d valid=%b led=%b expected in1=%0d in2=%0d valid=%b led=%b",
                         $time, in1, in2, operands_valid, state_led,
                         m_in1, m_in2, m_valid, m_state);
            end
        end
    end

    initial begin
        int sum;
        rst_n = 1'b0; btn_load = 1'b0; btn_clear = 1'b0; sw = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        check_lit("reset_in1", int'(in1), 0);
        check_lit("reset_in2", int'(in2), 0);
        check_lit("reset_valid", int'(operands_valid), 0);
        check_lit("reset_led", int'(state_led), 0);

        // 1: 2 + 4
        press_load(4'd2);
        press_load(4'd4);
        check_lit("s1_in1", int'(in1), 2);
        check_lit("s1_in2", int'(in2), 4);
        check_lit("s1_valid", int'(operands_valid), 1);
        sum = int'(in1) + int'(in2);
        check_lit("s1_adder_sum", sum & 15, 6);
        check_lit("s1_model_in2", int'(m_in2), 4);

        // 2: reload from READY with 10 then 15
        press_load(4'd10);
        press_load(4'd15);
        check_lit("s2_in1", int'(in1), 10);
        check_lit("s2_in2", int'(in2), 15);
        check_lit("s2_led", int'(state_led), 2);
        sum = int'(in1) + int'(in2);
        check_lit("s2_adder_sum", sum & 15, 9);
        check_lit("s2_adder_carry", (sum >> 4) & 1, 1);

        // 3: short glitch in WAIT_B is ignored
        press_load(4'd5);
        drive(1'b1, 1'b0, 4'd7, 2);
        drive(1'b0, 1'b0, 4'd7, 12);
        check_lit("s3_in2_held", int'(in2), 15);
        check_lit("s3_led", int'(state_led), 1);

        // 4: long hold from WAIT_A loads once
        drive(1'b0, 1'b1, 4'd7, 10);
        drive(1'b0, 1'b0, 4'd7, 10);
        check_lit("s4_clear_led", int'(state_led), 0);
        drive(1'b1, 1'b0, 4'd3, 100);
        drive(1'b0, 1'b0, 4'd3, 10);
        check_lit("s4_in1", int'(in1), 3);
        check_lit("s4_led", int'(state_led), 1);
        check_lit("s4_in2", int'(in2), 0);
        check_lit("s4_model_in1", int'(m_in1), 3);

        // 5: simultaneous LOAD and CLEAR from READY
        press_load(4'd9);
        check_lit("s5_pre_led", int'(state_led), 2);
        drive(1'b1, 1'b1, 4'd6, 10);
        drive(1'b0, 1'b0, 4'd6, 10);
        check_lit("s5_in1", int'(in1), 0);
        check_lit("s5_in2", int'(in2), 0);
        check_lit("s5_valid", int'(operands_valid), 0);
        check_lit("s5_led", int'(state_led), 0);

        // 6: async reset mid-debounce in WAIT_B
        press_load(4'd8);
        drive(1'b1, 1'b0, 4'd1, 3);
        #2;
        rst_n    = 1'b0;
        btn_load = 1'b0;
        model_reset();
        #1;
        check_lit("s6_async_in1", int'(in1), 0);
        check_lit("s6_async_led", int'(state_led), 0);
        check_lit("s6_async_valid", int'(operands_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 4'd1, 20);
        check_lit("s6_no_load_led", int'(state_led), 0);
        check_lit("s6_no_load_in1", int'(in1), 0);
        press_load(4'd1);
        check_lit("s6_fresh_in1", int'(in1), 1);
        check_lit("s6_fresh_led", int'(state_led), 1);

        // random button and switch activity
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                  W'($urandom_range(0, 15)), $urandom_range(1, 12));
        end
        drive(1'b0, 1'b0, '0, 12);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
